clock_divider_multi: RTL and testbench

Parametrised multi-channel clock divider, successor to the single-output delay-clock generator that drives the 7-segment display refresh and digit counters. Each of `N_CH` channels divides `i_clk` by a divisor that can be changed at run time. Each channel produces a one-cycle tick strobe and a 50 %-duty divided clock. Divisor changes take effect glitch-free at the channel's next wrap, and a global sync input phase-aligns all channels.

---
 rtl/clkdiv_pkg.sv | 13 +
 rtl/clkdiv_channel.sv | 83 ++++++++
 rtl/clock_divider_multi.sv | 55 +++++
 tb/tb_clock_divider_multi.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clkdiv_pkg;

    // Default counter/divisor width and reset-time divisor.
    localparam int CNT_W_DEF       = 24;
    localparam int DEFAULT_DIV_DEF = 2;

    // Width of a channel index: clog2(n), never less than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/shadow divisor, tick strobe and
// 50 %-duty divided clock. Divisor updates take effect only at a wrap,
// sync or while disabled, so the divided clock never glitches.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             div_clk,
    output logic             pending
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] shd;
    logic [CNT_W-1:0] eff_d;
    logic [CNT_W-1:0] wr_val;
    logic             pend;
    logic             wrap;
    logic             apply;

    // A divisor of zero is treated (and stored) as one.
    assign eff_d  = (div == '0) ? CNT_W'(1) : div;
    assign wr_val = (wr_div == '0) ? CNT_W'(1) : wr_div;

    // ">=" rather than "==" so a counter left beyond a freshly shrunk
    // divisor wraps on the next edge instead of running to 2^CNT_W.
    assign wrap  = (cnt >= eff_d - CNT_W'(1));
    assign apply = pend && (sync || !en || wrap);

    assign pending = pend;

    // Counter and registered outputs; sync beats disable beats wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values of its neighbours regardless of statement order.
        if (!rst_n) begin
            cnt     <= '0;
            tick    <= 1'b0;
            div_clk <= 1'b0;
        end else if (sync || !en) begin
            cnt     <= '0;
            tick    <= 1'b0;
            div_clk <= 1'b0;
        end else if (wrap) begin
            cnt     <= '0;
            tick    <= 1'b1;
            div_clk <= ~div_clk;
        end else begin
            cnt     <= cnt + CNT_W'(1);
            tick    <= 1'b0;
        end
    end

    // Active/shadow divisor; a same-cycle write stays pending for the next
    // apply point while the old shadow value is the one applied now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div  <= CNT_W'(DEFAULT_DIV);
            shd  <= CNT_W'(DEFAULT_DIV);
            pend <= 1'b0;
        end else begin
            if (apply) begin
                div <= shd;
            end
            if (wr) begin
                shd  <= wr_val;
                pend <= 1'b1;
            end else if (apply) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel run-time programmable clock divider. Decodes the divisor
// write strobe per channel and broadcasts sync to every channel.
module clock_divider_multi
    import clkdiv_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_CH-1:0]        i_en,
    input  logic                   i_sync,
    input  logic                   i_wr_en,
    input  logic [idx_w(N_CH)-1:0] i_wr_ch,
    input  logic [CNT_W-1:0]       i_wr_div,
    output logic [N_CH-1:0]        o_tick,
    output logic [N_CH-1:0]        o_div,
    output logic [N_CH-1:0]        o_pending
);

    localparam int IDX_W = idx_w(N_CH);

    logic [N_CH-1:0] wr_hit;

    // One-hot write decode; an index at or above N_CH matches nothing.
    always_comb begin
        // NOTE: default assigned first so no path leaves wr_hit unassigned,
        // which would otherwise infer a latch.
        wr_hit = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (i_wr_en && (i_wr_ch == IDX_W'(c))) begin
                wr_hit[c] = 1'b1;
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        clkdiv_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (i_clk),
            .rst_n   (i_rst),
            .en      (i_en[c]),
            .sync    (i_sync),
            .wr      (wr_hit[c]),
            .wr_div  (i_wr_div),
            .tick    (o_tick[c]),
            .div_clk (o_div[c]),
            .pending (o_pending[c])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi. A second five-channel instance
// exists only so that an out-of-range channel index (5) is representable.
module tb_clock_divider_multi;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [3:0]  i_en = '0;
    logic        i_sync = 1'b0;
    logic        i_wr_en = 1'b0;
    logic [1:0]  i_wr_ch = '0;
    logic [23:0] i_wr_div = '0;
    logic [3:0]  o_tick, o_div, o_pending;

    logic        i_wr_en5 = 1'b0;
    logic [2:0]  i_wr_ch5 = '0;
    logic [4:0]  o_tick5, o_div5, o_pending5;

    int n_cmp = 0;
    int n_bad = 0;

    clock_divider_multi #(.N_CH(4), .CNT_W(24), .DEFAULT_DIV(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_sync(i_sync),
        .i_wr_en(i_wr_en), .i_wr_ch(i_wr_ch), .i_wr_div(i_wr_div),
        .o_tick(o_tick), .o_div(o_div), .o_pending(o_pending)
    );

    clock_divider_multi #(.N_CH(5), .CNT_W(24), .DEFAULT_DIV(2)) dut5 (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(5'h1F), .i_sync(i_sync),
        .i_wr_en(i_wr_en5), .i_wr_ch(i_wr_ch5), .i_wr_div(i_wr_div),
        .o_tick(o_tick5), .o_div(o_div5), .o_pending(o_pending5)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic [3:0] e;
        logic [4:0] e5;

        // Reset state.
        step();
        step();
        check("rst_tick", 32'(o_tick), 32'h0);
        check("rst_div", 32'(o_div), 32'h0);
        check("rst_pend", 32'(o_pending), 32'h0);
        check("rst_tick5", 32'(o_tick5), 32'h0);

        // Default divisor 2: tick every 2 edges, o_div period 4.
        i_rst = 1'b1;
        i_en  = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("def_tick", 32'(o_tick), (k % 2 == 0) ? 32'hF : 32'h0);
            check("def_div", 32'(o_div), (((k / 2) % 2) == 1) ? 32'hF : 32'h0);
            check("def_pend", 32'(o_pending), 32'h0);
        end

        // Write ch1 div=5 mid-period (lands at E9, applied at wrap E10).
        i_wr_en = 1'b1; i_wr_ch = 2'd1; i_wr_div = 24'd5;
        step();
        i_wr_en = 1'b0;
        check("wr1_pend", 32'(o_pending), 32'h2);
        check("wr1_tick9", 32'(o_tick), 32'h0);
        for (int k = 10; k <= 20; k++) begin
            step();
            e = (k % 2 == 0) ? 4'b1101 : 4'b0000;
            if (k == 10 || k == 15 || k == 20) e[1] = 1'b1;
            check("div5_tick", 32'(o_tick), 32'(e));
            if (k == 10) check("wr1_pend_clr", 32'(o_pending), 32'h0);
        end
        check("div5_divclk", 32'(o_div), 32'h2);

        // Write 0 to ch2: behaves as D=1.
        i_wr_en = 1'b1; i_wr_ch = 2'd2; i_wr_div = 24'd0;
        step();
        i_wr_en = 1'b0;
        check("wr2_pend", 32'(o_pending), 32'h4);
        check("wr2_tick21", 32'(o_tick), 32'h0);
        step();
        check("wr2_pend_clr", 32'(o_pending), 32'h0);
        check("wr2_tick22", 32'(o_tick), 32'hD);
        check("wr2_div22", 32'(o_div[2]), 32'h1);
        for (int k = 23; k <= 28; k++) begin
            step();
            check("d1_tick", 32'(o_tick[2]), 32'h1);
            check("d1_div", 32'(o_div[2]), (k % 2 == 0) ? 32'h1 : 32'h0);
        end

        // ch0=3, ch3=7, let them drift, then sync.
        i_wr_en = 1'b1; i_wr_ch = 2'd0; i_wr_div = 24'd3;
        step();
        i_wr_ch = 2'd3; i_wr_div = 24'd7;
        step();
        i_wr_en = 1'b0;
        repeat (10) step();
        i_sync = 1'b1;
        step();
        i_sync = 1'b0;
        check("sync_div", 32'(o_div), 32'h0);
        check("sync_tick", 32'(o_tick), 32'h0);
        check("sync_pend", 32'(o_pending), 32'h0);
        check("sync_div5", 32'(o_div5), 32'h0);
        for (int j = 1; j <= 21; j++) begin
            step();
            e[0] = (j % 3 == 0);
            e[1] = (j % 5 == 0);
            e[2] = 1'b1;
            e[3] = (j % 7 == 0);
            check("post_sync_tick", 32'(o_tick), 32'(e));
        end

        // Disable ch0 with pending div=9.
        i_wr_en = 1'b1; i_wr_ch = 2'd0; i_wr_div = 24'd9;
        step();
        i_wr_en = 1'b0;
        check("wr0_pend", 32'(o_pending), 32'h1);
        i_en = 4'b1110;
        for (int j = 1; j <= 3; j++) begin
            step();
            check("dis_tick0", 32'(o_tick[0]), 32'h0);
            check("dis_div0", 32'(o_div[0]), 32'h0);
            check("dis_pend", 32'(o_pending), 32'h0);
        end
        i_en = 4'hF;
        for (int j = 1; j <= 9; j++) begin
            step();
            check("reen_tick0", 32'(o_tick[0]), (j == 9) ? 32'h1 : 32'h0);
        end
        check("reen_div0", 32'(o_div[0]), 32'h1);

        // Asynchronous reset between edges.
        #3;
        i_rst = 1'b0;
        #1;
        check("arst_tick", 32'(o_tick), 32'h0);
        check("arst_div", 32'(o_div), 32'h0);
        check("arst_pend", 32'(o_pending), 32'h0);
        check("arst_tick5", 32'(o_tick5), 32'h0);
        step();
        check("arst_hold", 32'(o_tick), 32'h0);

        // Release; write to nonexistent channel 5 of the 5-channel instance.
        i_rst = 1'b1;
        i_wr_en5 = 1'b1; i_wr_ch5 = 3'd5; i_wr_div = 24'd7;
        step();
        i_wr_en5 = 1'b0;
        check("oob_pend5", 32'(o_pending5), 32'h0);
        check("rel_tick1", 32'(o_tick), 32'h0);
        for (int j = 2; j <= 6; j++) begin
            step();
            e5 = (j % 2 == 0) ? 5'h1F : 5'h00;
            check("rel_tick", 32'(o_tick), (j % 2 == 0) ? 32'hF : 32'h0);
            check("oob_tick5", 32'(o_tick5), 32'(e5));
            check("oob_pend5b", 32'(o_pending5), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
